dadda_mul_arbiter: RTL and testbench

//   Shares one combinational dadda_multiplier_32 between NUM_REQ requesters.
//   - Round-robin arbitration.
//   - Registers operands so the multiplier runs as a MUL_CYCLES multicycle path.
//   - Returns a registered 64-bit signed product tagged with the requester ID,

---
 rtl/dadda_mul_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_dadda_mul_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dadda_mul_arbiter.sv
// Round-robin front end sharing one combinational 32x32 signed multiplier between
// NUM_REQ requesters; operands are registered so the multiplier is a MUL_CYCLES multicycle path.

module dadda_multiplier_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    // Row heights after each carry-save stage, following the Dadda sequence down to two rows.
    function automatic int dadda_h(input int s);
        case (s)
            0: dadda_h = 33;
            1: dadda_h = 28;
            2: dadda_h = 19;
            3: dadda_h = 13;
            4: dadda_h = 9;
            5: dadda_h = 6;
            6: dadda_h = 4;
            7: dadda_h = 3;
            default: dadda_h = 2;
        endcase
    endfunction

    logic [63:0] rows [0:32];
    logic [63:0] nxt  [0:32];
    logic [63:0] a_ext;
    logic [63:0] x, y, z;
    int          h, kk;

    always_comb begin
        a_ext = {{32{a[31]}}, a};
        x = '0;
        y = '0;
        z = '0;
        h = 0;
        kk = 0;
        for (int i = 0; i < 31; i++) rows[i] = b[i] ? (a_ext << i) : 64'd0;
        // b[31] carries weight -2^31: subtract its row as ~row + 1.
        rows[31] = ~(b[31] ? (a_ext << 31) : 64'd0);
        rows[32] = 64'd1;
        for (int s = 0; s < 8; s++) begin
            h  = dadda_h(s);
            kk = h - dadda_h(s + 1);
            for (int j = 0; j < 33; j++) nxt[j] = '0;
            for (int k = 0; k < 11; k++) begin
                if (k < kk) begin
                    x = rows[3*k];
                    y = rows[3*k+1];
                    z = rows[3*k+2];
                    nxt[2*k]   = x ^ y ^ z;
                    nxt[2*k+1] = ((x & y) | (x & z) | (y & z)) << 1;
                end
            end
            for (int m = 0; m < 33; m++) begin
                if (m >= 3*kk && m < h) nxt[m-kk] = rows[m];
            end
            for (int j = 0; j < 33; j++) rows[j] = nxt[j];
        end
        p = rows[0] + rows[1];
    end
endmodule

module dadda_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MUL_CYCLES = 2,
    parameter int ID_W       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_product,
    output logic [ID_W-1:0]         out_id,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam int            CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [ID_W:0] NREQ_W   = (ID_W+1)'(NUM_REQ);

    state_t                      state_q, state_d;
    logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [31:0]                 op_a_q, op_a_d, op_b_q, op_b_d;
    logic [ID_W-1:0]             id_q, id_d;
    logic [63:0]                 out_product_q, out_product_d;
    logic [ID_W-1:0]             out_id_q, out_id_d;

    logic [NUM_REQ-1:0][31:0]    a_arr, b_arr;
    logic [NUM_REQ-1:0]          grant;
    logic                        found;
    logic [ID_W-1:0]             win_idx;
    logic [ID_W:0]               cand, nxt_ptr;
    logic [63:0]                 mul_p;

    assign a_arr = req_a;
    assign b_arr = req_b;

    dadda_multiplier_32 u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (mul_p)
    );

    // Search rr_ptr, rr_ptr+1, ... modulo NUM_REQ for the first pending request.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[ID_W-1:0];
            end
        end
        nxt_ptr = {1'b0, win_idx} + 1'b1;
        if (nxt_ptr == NREQ_W) nxt_ptr = '0;
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        id_d          = id_q;
        out_product_d = out_product_q;
        out_id_d      = out_id_q;
        grant         = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant[win_idx] = 1'b1;
                    op_a_d   = a_arr[win_idx];
                    op_b_d   = b_arr[win_idx];
                    id_d     = win_idx;
                    rr_ptr_d = nxt_ptr[ID_W-1:0];
                    cnt_d    = CNT_INIT;
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out_product_d = mul_p;
                    out_id_d      = id_q;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            id_q          <= '0;
            out_product_q <= '0;
            out_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            id_q          <= id_d;
            out_product_q <= out_product_d;
            out_id_q      <= out_id_d;
        end
    end

    assign req_ready   = rst_n ? grant : '0;
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign out_product = out_product_q;
    assign out_id      = out_id_q;
endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Directed bench for dadda_mul_arbiter: grant timing, round-robin order, signed products,
// backpressure and mid-operation reset, checked with immediate assertions.

module tb_dadda_mul_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a, req_b;
    logic                  out_valid, out_ready, busy;
    logic [63:0]           out_product;
    logic [ID_W-1:0]       out_id;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dadda_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_CYCLES(2), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_id      (out_id),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // Called at a negedge in IDLE with req_valid already driven; returns at the
    // negedge of cycle T+3 where the result is presented.
    task automatic issue(input int win, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_prod);
        set_op(win, a, b);
        #1;
        chk("grant_ready", 64'(req_ready), 64'(4'b0001 << win));
        @(negedge clk);
        set_op(win, $urandom, $urandom);
        #1;
        chk("mul1_busy", 64'(busy), 64'd1);
        chk("mul1_ready", 64'(req_ready), 64'd0);
        chk("mul1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("mul2_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("done_valid", 64'(out_valid), 64'd1);
        chk("done_id", 64'(out_id), 64'(win));
        chk("done_prod", out_product, exp_prod);
        set_op(win, a, b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_prod", out_product, 64'd0);
        chk("rst_id", 64'(out_id), 64'd0);
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        req_a = '0;
        req_b = '0;
        do_reset();

        // 5 * -3 on requester 0, then 10 cycles of backpressure.
        out_ready = 1'b0;
        req_valid = 4'b0001;
        issue(0, 32'd5, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1);
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_prod", out_product, 64'hFFFF_FFFF_FFFF_FFF1);
            chk("bp_id", 64'(out_id), 64'd0);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_busy", 64'(busy), 64'd0);

        // Most-negative squared on requester 1 (rr_ptr now 1).
        req_valid = 4'b0010;
        issue(1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        @(negedge clk);
        req_valid = '0;

        // All four requesting with out_ready held: 0,1,2,3,0 at 4-cycle spacing.
        do_reset();
        out_ready = 1'b1;
        set_op(0, 32'd3, 32'd4);
        set_op(1, 32'hFFFF_FFFA, 32'd7);
        set_op(2, 32'd100000, 32'hFFFE_7960);
        set_op(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        req_valid = 4'b1111;
        issue(0, 32'd3, 32'd4, 64'd12);
        @(negedge clk);
        issue(1, 32'hFFFF_FFFA, 32'd7, 64'hFFFF_FFFF_FFFF_FFD6);
        @(negedge clk);
        issue(2, 32'd100000, 32'hFFFE_7960, 64'hFFFF_FFFD_ABF4_1C00);
        @(negedge clk);
        issue(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        @(negedge clk);
        issue(0, 32'd3, 32'd4, 64'd12);
        @(negedge clk);

        // Reset during MUL for a requester-2 operation: result is discarded.
        req_valid = 4'b0100;
        #1;
        chk("r5_grant", 64'(req_ready), 64'b0100);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("r5_ready_in_rst", 64'(req_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("r5_valid", 64'(out_valid), 64'd0);
        chk("r5_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        issue(0, 32'd3, 32'd4, 64'd12);
        @(negedge clk);

        // Requesters 1 and 3 alternate with no starvation (rr_ptr now 1).
        set_op(1, 32'd7, 32'hFFFF_FFF7);
        set_op(3, 32'd7, 32'hFFFF_FFF7);
        req_valid = 4'b1010;
        for (int r = 0; r < 2; r++) begin
            issue(1, 32'd7, 32'hFFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFC1);
            @(negedge clk);
            issue(3, 32'd7, 32'hFFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFC1);
            @(negedge clk);
        end
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
